// File: rtl/neuron_lanes.sv
// neuron_lanes: LANES-wide MAC neuron with saturating fixed-point accumulation,
// bias, runtime-selectable activation and valid/ready handshakes on both sides.
module neuron_lanes #(
    parameter int LAYER_NO   = 0,
    parameter int NEURON_NO  = 0,
    parameter int NUM_WEIGHT = 784,
    parameter int DATA_WIDTH = 16,
    parameter int INT_WIDTH  = 4,
    parameter int LANES      = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [LANES*DATA_WIDTH-1:0] in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        weight_valid,
    input  logic [31:0]                 weight_value,
    input  logic                        bias_valid,
    input  logic [31:0]                 bias_value,
    input  logic [31:0]                 config_layer_num,
    input  logic [31:0]                 config_neuron_num,
    input  logic [1:0]                  act_sel,
    output logic [DATA_WIDTH-1:0]       out,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        busy
);
    localparam int FRAC  = DATA_WIDTH - INT_WIDTH;
    localparam int BEATS = (NUM_WEIGHT + LANES - 1) / LANES;
    localparam int AW    = 2 * DATA_WIDTH;
    localparam int SW    = AW + $clog2(LANES);
    localparam int XW    = SW + 1;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int LBW   = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [LBW-1:0] LAST_BANK = LBW'((NUM_WEIGHT - 1) % LANES);
    localparam logic [LBW-1:0] TOP_BANK  = LBW'(LANES - 1);
    localparam logic [BW-1:0]  LAST_BEAT = BW'(BEATS - 1);

    typedef enum logic [2:0] {IDLE, ACCUM, DRAIN, BIAS, ACT, HOLD} state_t;

    // Clamp a wide signed sum into the accumulator range.
    function automatic logic signed [AW-1:0] sat_acc(input logic signed [XW-1:0] v);
        logic [XW-AW:0] top;
        top = v[XW-1:AW-1];
        if ((&top) || !(|top)) sat_acc = v[AW-1:0];
        else if (v[XW-1])      sat_acc = {1'b1, {(AW-1){1'b0}}};
        else                   sat_acc = {1'b0, {(AW-1){1'b1}}};
    endfunction

    // Clamp an accumulator-width value into the output range.
    function automatic logic signed [DATA_WIDTH-1:0] sat_out(input logic signed [AW-1:0] v);
        logic [AW-DATA_WIDTH:0] top;
        top = v[AW-1:DATA_WIDTH-1];
        if ((&top) || !(|top)) sat_out = v[DATA_WIDTH-1:0];
        else if (v[AW-1])      sat_out = {1'b1, {(DATA_WIDTH-1){1'b0}}};
        else                   sat_out = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    endfunction

    state_t state_r, state_next_s;
    logic [BW-1:0]  beat_cnt_r;
    logic [LBW-1:0] wbank_r;
    logic [BW-1:0]  waddr_r;
    logic signed [DATA_WIDTH-1:0] bias_r;
    logic signed [AW-1:0] acc_r;
    logic v1_r, v2_r, v3_r;
    logic [DATA_WIDTH-1:0] out_r;
    logic out_valid_r, in_ready_r, busy_r;

    logic [DATA_WIDTH-1:0] mem [LANES][BEATS];
    logic signed [DATA_WIDTH-1:0] d1_r [LANES];
    logic signed [DATA_WIDTH-1:0] w1_r [LANES];
    logic signed [AW-1:0] p2_r [LANES];
    logic signed [SW-1:0] s3_r;

    logic accept_s, last_beat_s, hit_s, cfg_ok_s, wr_en_s;
    logic [LANES-1:0] lane_mask_s;
    logic signed [SW-1:0] sum_s;
    logic signed [AW-1:0] acc_sum_s, acc_bias_s, bias_sh_s;
    logic signed [DATA_WIDTH-1:0] y_s, act_s;
    logic unused_bits;

    assign unused_bits = ^{weight_value[31:DATA_WIDTH], bias_value[31:DATA_WIDTH]};

    assign in_ready  = in_ready_r;
    assign out       = out_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;

    // Handshake, config-address decode and last-beat detection.
    always_comb begin
        accept_s    = in_valid && in_ready_r;
        last_beat_s = (beat_cnt_r == LAST_BEAT);
        hit_s       = (config_layer_num == 32'(LAYER_NO)) && (config_neuron_num == 32'(NEURON_NO));
        cfg_ok_s    = hit_s && (state_r == IDLE);
        wr_en_s     = cfg_ok_s && weight_valid;
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) state_next_s = last_beat_s ? DRAIN : ACCUM;
                else          state_next_s = IDLE;
            end
            ACCUM: begin
                if (accept_s && last_beat_s) state_next_s = DRAIN;
                else                         state_next_s = ACCUM;
            end
            // The stage-3 sum lands in ACC on this same edge, so BIAS sees the full sum.
            DRAIN: begin
                if (!v1_r && !v2_r) state_next_s = BIAS;
                else                state_next_s = DRAIN;
            end
            BIAS: state_next_s = ACT;
            ACT:  state_next_s = HOLD;
            HOLD: begin
                if (out_ready) state_next_s = IDLE;
                else           state_next_s = HOLD;
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Lanes past the last real weight contribute zero.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            lane_mask_s[i] = ((int'(beat_cnt_r) * LANES) + i) >= NUM_WEIGHT;
        end
    end

    // Adder tree plus saturating accumulate and bias arithmetic.
    always_comb begin
        sum_s = {SW{1'b0}};
        for (int i = 0; i < LANES; i++) begin
            sum_s = sum_s + SW'(p2_r[i]);
        end
        bias_sh_s  = AW'(bias_r) <<< FRAC;
        acc_sum_s  = sat_acc(XW'(acc_r) + XW'(s3_r));
        acc_bias_s = sat_acc(XW'(acc_r) + XW'(bias_sh_s));
    end

    // Output scaling and activation.
    always_comb begin
        y_s = sat_out(acc_r >>> FRAC);
        case (act_sel)
            2'd1:    act_s = y_s[DATA_WIDTH-1] ? {DATA_WIDTH{1'b0}} : y_s;
            2'd2:    act_s = y_s[DATA_WIDTH-1] ? (y_s >>> 3) : y_s;
            default: act_s = y_s;
        endcase
    end

    // Control state, pointers, accumulator and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            beat_cnt_r  <= {BW{1'b0}};
            wbank_r     <= {LBW{1'b0}};
            waddr_r     <= {BW{1'b0}};
            bias_r      <= {DATA_WIDTH{1'b0}};
            acc_r       <= {AW{1'b0}};
            v1_r        <= 1'b0;
            v2_r        <= 1'b0;
            v3_r        <= 1'b0;
            out_r       <= {DATA_WIDTH{1'b0}};
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            in_ready_r  <= (state_next_s == IDLE) || (state_next_s == ACCUM);
            busy_r      <= (state_next_s != IDLE);
            out_valid_r <= (state_next_s == HOLD);
            v1_r        <= accept_s;
            v2_r        <= v1_r;
            v3_r        <= v2_r;
            if (accept_s) beat_cnt_r <= last_beat_s ? {BW{1'b0}} : beat_cnt_r + BW'(1);
            if (wr_en_s) begin
                if ((waddr_r == LAST_BEAT) && (wbank_r == LAST_BANK)) begin
                    wbank_r <= {LBW{1'b0}};
                    waddr_r <= {BW{1'b0}};
                end else if (wbank_r == TOP_BANK) begin
                    wbank_r <= {LBW{1'b0}};
                    waddr_r <= waddr_r + BW'(1);
                end else begin
                    wbank_r <= wbank_r + LBW'(1);
                end
            end
            if (cfg_ok_s && bias_valid) bias_r <= bias_value[DATA_WIDTH-1:0];
            if (accept_s && (state_r == IDLE)) acc_r <= {AW{1'b0}};
            else if (v3_r)                     acc_r <= acc_sum_s;
            else if (state_r == BIAS)          acc_r <= acc_bias_s;
            if (state_r == ACT) out_r <= act_s;
        end
    end

    // Weight banks and MAC pipeline datapath; contents are qualified by the valids.
    always_ff @(posedge clk) begin
        if (wr_en_s) mem[wbank_r][waddr_r] <= weight_value[DATA_WIDTH-1:0];
        for (int i = 0; i < LANES; i++) begin
            d1_r[i] <= lane_mask_s[i] ? {DATA_WIDTH{1'b0}} : in_data[i*DATA_WIDTH +: DATA_WIDTH];
            w1_r[i] <= lane_mask_s[i] ? {DATA_WIDTH{1'b0}} : mem[i][beat_cnt_r];
            p2_r[i] <= d1_r[i] * w1_r[i];
        end
        s3_r <= sum_s;
    end
endmodule

// File: tb/tb_neuron_lanes.sv
// Directed bench for neuron_lanes: two instances (8 and 6 weights) share the
// config bus; expected results go through a scoreboard queue.
module tb_neuron_lanes;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, sel, in_valid, weight_valid, bias_valid, out_ready;
    logic [63:0] in_data;
    logic [31:0] weight_value, bias_value, cfg_layer, cfg_neuron;
    logic [1:0]  act_sel;
    logic in_valid8, in_valid6, in_ready8, in_ready6, out_valid8, out_valid6, busy8, busy6;
    logic [15:0] out8, out6;
    logic [15:0] out_o;
    logic in_ready_o, out_valid_o, busy_o;

    int errors = 0;
    int checks = 0;
    logic [15:0] exp_q[$];

    assign in_valid8   = in_valid & ~sel;
    assign in_valid6   = in_valid & sel;
    assign out_o       = sel ? out6 : out8;
    assign in_ready_o  = sel ? in_ready6 : in_ready8;
    assign out_valid_o = sel ? out_valid6 : out_valid8;
    assign busy_o      = sel ? busy6 : busy8;

    neuron_lanes #(.LAYER_NO(0), .NEURON_NO(0), .NUM_WEIGHT(8), .DATA_WIDTH(16),
                   .INT_WIDTH(4), .LANES(4)) dut8 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid8), .in_ready(in_ready8),
        .weight_valid(weight_valid), .weight_value(weight_value),
        .bias_valid(bias_valid), .bias_value(bias_value),
        .config_layer_num(cfg_layer), .config_neuron_num(cfg_neuron), .act_sel(act_sel),
        .out(out8), .out_valid(out_valid8), .out_ready(out_ready), .busy(busy8));

    neuron_lanes #(.LAYER_NO(0), .NEURON_NO(1), .NUM_WEIGHT(6), .DATA_WIDTH(16),
                   .INT_WIDTH(4), .LANES(4)) dut6 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid6), .in_ready(in_ready6),
        .weight_valid(weight_valid), .weight_value(weight_value),
        .bias_valid(bias_valid), .bias_value(bias_value),
        .config_layer_num(cfg_layer), .config_neuron_num(cfg_neuron), .act_sel(act_sel),
        .out(out6), .out_valid(out_valid6), .out_ready(out_ready), .busy(busy6));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cfg_write(input logic [31:0] neuron, input logic wv, input logic [31:0] w,
                             input logic bv, input logic [31:0] b);
        cfg_neuron = neuron; weight_valid = wv; weight_value = w;
        bias_valid = bv; bias_value = b;
        tick();
        weight_valid = 1'b0; bias_valid = 1'b0;
    endtask

    task automatic load_weights(input logic [31:0] neuron, input logic [31:0] w, input int n);
        for (int i = 0; i < n; i++) cfg_write(neuron, 1'b1, w, 1'b0, 32'h0);
    endtask

    task automatic send_beat(input logic [63:0] d);
        int k;
        k = 0;
        in_data = d; in_valid = 1'b1;
        while (!in_ready_o && k < 50) begin tick(); k++; end
        check("in_ready_for_beat", {31'b0, in_ready_o}, 32'h1);
        tick();
        in_valid = 1'b0;
    endtask

    // Two beats, then result/latency/hold/handshake checks against the scoreboard.
    task automatic run(input string tag, input logic [63:0] d0, input logic [63:0] d1,
                       input logic [15:0] exp, input int hold);
        int k;
        logic [15:0] e;
        exp_q.push_back(exp);
        out_ready = (hold == 0);
        send_beat(d0);
        send_beat(d1);
        check({tag, "_in_ready_after_last"}, {31'b0, in_ready_o}, 32'h0);
        check({tag, "_busy_after_last"}, {31'b0, busy_o}, 32'h1);
        k = 0;
        while (!out_valid_o && k < 20) begin tick(); k++; end
        check({tag, "_latency"}, k, 32'd5);
        e = exp_q.pop_front();
        check({tag, "_out"}, {16'h0, out_o}, {16'h0, e});
        for (int i = 0; i < hold; i++) begin
            weight_valid = 1'b1; weight_value = 32'h7FFF; cfg_neuron = sel ? 32'd1 : 32'd0;
            tick();
            weight_valid = 1'b0;
            check({tag, "_hold_out"}, {16'h0, out_o}, {16'h0, e});
            check({tag, "_hold_valid"}, {31'b0, out_valid_o}, 32'h1);
            check({tag, "_hold_in_ready"}, {31'b0, in_ready_o}, 32'h0);
            check({tag, "_hold_busy"}, {31'b0, busy_o}, 32'h1);
        end
        out_ready = 1'b1;
        tick();
        check({tag, "_post_valid"}, {31'b0, out_valid_o}, 32'h0);
        check({tag, "_post_in_ready"}, {31'b0, in_ready_o}, 32'h1);
        check({tag, "_post_busy"}, {31'b0, busy_o}, 32'h0);
    endtask

    initial begin
        rst = 1'b1; sel = 1'b0; in_valid = 1'b0; in_data = 64'h0;
        weight_valid = 1'b0; bias_valid = 1'b0; weight_value = 32'h0; bias_value = 32'h0;
        cfg_layer = 32'h0; cfg_neuron = 32'h0; act_sel = 2'd0; out_ready = 1'b1;
        tick(); tick();
        rst = 1'b0;
        check("rst_in_ready", {31'b0, in_ready_o}, 32'h1);
        check("rst_out_valid", {31'b0, out_valid_o}, 32'h0);
        check("rst_out", {16'h0, out_o}, 32'h0);
        check("rst_busy", {31'b0, busy_o}, 32'h0);

        // Six-weight neuron: masked lanes carry 0x7FFF and must be ignored.
        sel = 1'b1;
        load_weights(32'd1, 32'h1000, 6);
        act_sel = 2'd0;
        run("mask", {4{16'h1000}}, {16'h7FFF, 16'h7FFF, 16'h1000, 16'h1000}, 16'h6000, 0);

        // Eight-weight neuron: bias written together with the first weight.
        sel = 1'b0;
        cfg_write(32'd0, 1'b1, 32'h1000, 1'b1, 32'h1000);
        load_weights(32'd0, 32'h1000, 7);
        act_sel = 2'd1;
        run("basic_hold", {4{16'h0800}}, {4{16'h0800}}, 16'h5000, 10);
        run("after_hold", {4{16'h0800}}, {4{16'h0800}}, 16'h5000, 0);

        cfg_write(32'd0, 1'b0, 32'h0, 1'b1, 32'h0);
        act_sel = 2'd0;
        run("neg_none", {4{16'hFC00}}, {4{16'hFC00}}, 16'hE000, 0);
        act_sel = 2'd1;
        run("neg_relu", {4{16'hFC00}}, {4{16'hFC00}}, 16'h0000, 0);
        act_sel = 2'd2;
        run("neg_leaky", {4{16'hFC00}}, {4{16'hFC00}}, 16'hFC00, 0);

        load_weights(32'd0, 32'h7FFF, 8);
        act_sel = 2'd0;
        run("saturate", {4{16'h7FFF}}, {4{16'h7FFF}}, 16'h7FFF, 0);

        // Abort mid-accumulation; bias must come back as zero.
        load_weights(32'd0, 32'h1000, 8);
        cfg_write(32'd0, 1'b0, 32'h0, 1'b1, 32'h1000);
        act_sel = 2'd1;
        send_beat({4{16'h7FFF}});
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_in_ready", {31'b0, in_ready_o}, 32'h1);
        check("abort_busy", {31'b0, busy_o}, 32'h0);
        check("abort_out_valid", {31'b0, out_valid_o}, 32'h0);
        check("abort_out", {16'h0, out_o}, 32'h0);
        run("after_abort", {4{16'h0800}}, {4{16'h0800}}, 16'h4000, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
